// File: rtl/apb_rx_pkg.sv
// rtl/apb_rx_pkg.sv - shared state type, limits and data-length clamp for the UART RX frame engine
package apb_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_t;

  localparam int MIN_DATA_W = 5;

  // Out-of-range lengths fall back to the full data width.
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_w);
    if (int'(len) < MIN_DATA_W || int'(len) > max_w) return 5'(max_w);
    return len;
  endfunction

endpackage

// File: rtl/apb_rx_sampler.sv
// rtl/apb_rx_sampler.sv - rx synchroniser and three-sample majority voter
module apb_rx_sampler #(
  parameter  int OSR = 16,
  localparam int CW  = $clog2(OSR)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx,
  input  logic          os_tick,
  input  logic [CW-1:0] os_cnt,
  output logic          rx_sync,
  output logic          bit_val
);

  logic meta;
  logic s0;
  logic s1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      s0      <= 1'b1;
      s1      <= 1'b1;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
      if (os_tick && os_cnt == CW'(OSR/2 - 1)) s0 <= rx_sync;
      if (os_tick && os_cnt == CW'(OSR/2))     s1 <= rx_sync;
    end
  end

  // Third sample is the live synchronised value, so the vote is ready on the OSR/2+1 tick.
  assign bit_val = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

endmodule

// File: rtl/apb_rx_frame.sv
// rtl/apb_rx_frame.sv - oversampled UART RX frame engine; APB_RX_PARITY_EN adds the parity bit
module apb_rx_frame
  import apb_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic              rx_en,
  input  logic              os_tick,
  input  logic              rx,
  input  logic [4:0]        data_len,
  input  logic              stop2,
`ifdef APB_RX_PARITY_EN
  input  logic              par_en,
  input  logic              par_odd,
`endif
  input  logic              err_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] MID  = CW'(OSR/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  rx_state_t         state, state_nxt;
  logic [CW-1:0]     os_cnt;
  logic [4:0]        bit_cnt;
  logic [4:0]        len_q;
  logic              stop2_q;
  logic [DATA_W-1:0] data_sh;
  logic              fe_pend;
  logic              rx_sync;
  logic              bit_val;
  logic              en, mid, last, done;
  logic              fe_new, pe_new;

`ifdef APB_RX_PARITY_EN
  logic par_en_q, par_odd_q, par_acc, pe_pend;
  assign pe_new = pe_pend;
`else
  assign pe_new = 1'b0;
`endif

  apb_rx_sampler #(.OSR(OSR)) u_sampler (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .os_tick (os_tick),
    .os_cnt  (os_cnt),
    .rx_sync (rx_sync),
    .bit_val (bit_val)
  );

  assign en     = sel & rx_en;
  assign mid    = os_tick && os_cnt == MID;
  assign last   = os_tick && os_cnt == LAST;
  assign fe_new = !bit_val | (state == STOP2 && fe_pend);
  assign busy   = state != IDLE;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (os_tick && !rx_sync) state_nxt = START;
      START:  if (mid && bit_val) state_nxt = IDLE;
              else if (last)      state_nxt = DATA;
      DATA:   if (last && bit_cnt == len_q - 5'd1) begin
`ifdef APB_RX_PARITY_EN
                state_nxt = par_en_q ? PARITY : STOP1;
`else
                state_nxt = STOP1;
`endif
              end
`ifdef APB_RX_PARITY_EN
      PARITY: if (last) state_nxt = STOP1;
`endif
      STOP1:  if (mid && !stop2_q) begin
                done      = 1'b1;
                state_nxt = IDLE;
              end else if (last) state_nxt = STOP2;
      STOP2:  if (mid) begin
                done      = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
    // Disabling aborts silently: no completion, no flags.
    if (!en) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      len_q   <= 5'(DATA_W);
      stop2_q <= 1'b0;
      data_sh <= '0;
      fe_pend <= 1'b0;
`ifdef APB_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc   <= 1'b0;
      pe_pend   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
      end else if (os_tick) begin
        os_cnt <= last ? '0 : os_cnt + 1'b1;
      end
      if (state == START && state_nxt == DATA) begin
        bit_cnt <= '0;
        data_sh <= '0;
        fe_pend <= 1'b0;
        len_q   <= clamp_len(data_len, DATA_W);
        stop2_q <= stop2;
`ifdef APB_RX_PARITY_EN
        par_en_q  <= par_en;
        par_odd_q <= par_odd;
        par_acc   <= 1'b0;
        pe_pend   <= 1'b0;
`endif
      end
      if (en && state == DATA) begin
        if (mid) begin
          for (int i = 0; i < DATA_W; i++)
            if (bit_cnt == 5'(i)) data_sh[i] <= bit_val;
`ifdef APB_RX_PARITY_EN
          par_acc <= par_acc ^ bit_val;
`endif
        end
        if (last) bit_cnt <= bit_cnt + 5'd1;
      end
`ifdef APB_RX_PARITY_EN
      if (en && state == PARITY && mid) pe_pend <= bit_val != (par_acc ^ par_odd_q);
`endif
      if (en && state == STOP1 && mid) fe_pend <= !bit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_data   <= data_sh;
        frame_err <= fe_new;
        par_err   <= pe_new;
        rx_valid  <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (err_clr)                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_rx_frame.sv
// tb/tb_apb_rx_frame.sv - self-checking bench for apb_rx_frame against a frame-level reference model
module tb_apb_rx_frame;

  localparam int DATA_W = 8;
  localparam int OSR    = 16;
`ifdef APB_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0, sel = 1'b1, rx_en = 1'b1, os_tick = 1'b0, rx = 1'b1;
  logic stop2 = 1'b0, par_en = 1'b0, par_odd = 1'b0, err_clr = 1'b0, rx_ready = 1'b0;
  logic [4:0] data_len = 5'd8;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid, frame_err, par_err, overrun, busy;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] e_data = '0;
  bit e_valid = 0, e_fe = 0, e_pe = 0, e_ovr = 0;
  int lat;
  bit busy_seen;

  apb_rx_frame #(.DATA_W(DATA_W), .OSR(OSR)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .rx_en(rx_en), .os_tick(os_tick), .rx(rx),
    .data_len(data_len), .stop2(stop2),
`ifdef APB_RX_PARITY_EN
    .par_en(par_en), .par_odd(par_odd),
`endif
    .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .par_err(par_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 os_tick = ~os_tick;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] obs();
    return {rx_valid, rx_data, frame_err, par_err, overrun};
  endfunction

  function automatic logic [11:0] mdl();
    return {e_valid, e_data, e_fe, e_pe, e_ovr};
  endfunction

  task automatic tk(input int n);
    repeat (n) begin
      do @(posedge clk); while (os_tick !== 1'b1);
    end
    #2;
  endtask

  task automatic drive(input bit v, input int n);
    rx = v;
    for (int k = 0; k < n; k++) begin
      tk(1);
      busy_seen |= busy;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int len_cfg, input bit s2, p_en, p_odd,
                            input bit stop_a, stop_b, flip, input int glitch, input int idle);
    int L;
    logic [7:0] m;
    bit pb, fin, fe, pe;
    L = (len_cfg < 5 || len_cfg > DATA_W) ? DATA_W : len_cfg;
    data_len = 5'(len_cfg);
    stop2 = s2; par_en = p_en; par_odd = p_odd;
    m  = 8'((1 << L) - 1);
    pb = ^(d & m) ^ par_odd ^ flip;
    lat = -1;
    drive(1'b0, OSR);
    for (int i = 0; i < L; i++) begin
      if (i == glitch) begin
        drive(1'b1, 8); drive(1'b0, 1); drive(1'b1, 7);
      end else drive(d[i], OSR);
    end
    if (PAR && p_en) drive(pb, OSR);
    if (s2) begin
      drive(stop_a, OSR);
      fin = stop_b;
    end else fin = stop_a;
    rx = fin;
    for (int k = 1; k <= OSR; k++) begin
      tk(1);
      if (lat < 0 && rx_valid) lat = k;
    end
    rx = 1'b1;
    if (idle > 0) drive(1'b1, idle);
    fe = !stop_a || (s2 && !stop_b);
    pe = PAR && par_en && flip;
    if (!e_valid) begin
      e_data = d & m; e_fe = fe; e_pe = pe; e_valid = 1;
    end else e_ovr = 1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk);
    #2 rx_ready = 1'b0;
    e_valid = 0;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #2 rstn = 1'b1;
    n_cmp++;
    if (obs() !== 12'h000) begin n_bad++; $display("FAIL reset_outputs: got %h want 000", obs()); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    tk(1);
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0, -1, 24);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL basic_frame: got %h want %h", obs(), mdl()); end
    n_cmp++;
    if (lat != 11) begin n_bad++; $display("FAIL basic_latency: got tick %0d want tick 11", lat); end
    consume();
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL basic_consume: got %h want %h", obs(), mdl()); end
  endtask

  task automatic test_false_start();
    tk(1);
    busy_seen = 0;
    drive(1'b0, 6);
    drive(1'b1, 30);
    n_cmp++;
    if (busy_seen !== 1'b1) begin n_bad++; $display("FAIL false_start_busy_pulse: got %b want 1", busy_seen); end
    n_cmp++;
    if ({busy, obs()} !== {1'b0, mdl()}) begin n_bad++; $display("FAIL false_start_idle: got %h want %h", {busy, obs()}, {1'b0, mdl()}); end
  endtask

  task automatic test_parity_7e2();
    tk(1);
    send_frame(8'h3C, 7, 1, 1, 0, 1, 0, 0, -1, 24);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL frame_err_7e2: got %h want %h", obs(), mdl()); end
    consume();
    send_frame(8'h3C, 7, 1, 1, 0, 1, 1, 1, -1, 24);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL par_err_7e2: got %h want %h", obs(), mdl()); end
    consume();
  endtask

  task automatic test_overrun();
    tk(1);
    send_frame(8'h11, 8, 0, 0, 0, 1, 1, 0, -1, 0);
    send_frame(8'h22, 8, 0, 0, 0, 1, 1, 0, -1, 24);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL overrun_set: got %h want %h", obs(), mdl()); end
    err_clr = 1'b1;
    @(posedge clk);
    #2 err_clr = 1'b0;
    e_ovr = 0;
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL overrun_clear: got %h want %h", obs(), mdl()); end
    consume();
  endtask

  task automatic test_glitch();
    tk(1);
    send_frame(8'hFF, 8, 0, 0, 0, 1, 1, 0, 3, 24);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL glitch_vote: got %h want %h", obs(), mdl()); end
    consume();
  endtask

  task automatic test_rx_en_drop();
    logic [7:0] d;
    tk(1);
    send_frame(8'h77, 8, 0, 0, 0, 1, 1, 0, -1, 24);
    d = 8'h5A;
    data_len = 5'd8; stop2 = 1'b0;
    busy_seen = 0;
    drive(1'b0, OSR);
    for (int i = 0; i < 4; i++) drive(d[i], OSR);
    drive(d[4], 8);
    rx_en = 1'b0;
    drive(d[4], 8);
    n_cmp++;
    if ({busy_seen, busy} !== 2'b10) begin n_bad++; $display("FAIL rx_en_abort_busy: got %b want 10", {busy_seen, busy}); end
    for (int i = 5; i < 8; i++) drive(d[i], OSR);
    drive(1'b1, OSR);
    n_cmp++;
    if (obs() !== mdl()) begin n_bad++; $display("FAIL rx_en_hold: got %h want %h", obs(), mdl()); end
    consume();
    rx_en = 1'b1;
    drive(1'b1, 24);
    n_cmp++;
    if ({busy, obs()} !== {1'b0, mdl()}) begin n_bad++; $display("FAIL rx_en_no_output: got %h want %h", {busy, obs()}, {1'b0, mdl()}); end
  endtask

  task automatic test_reset_midframe();
    tk(1);
    send_frame(8'h99, 8, 0, 0, 0, 1, 1, 0, -1, 24);
    drive(1'b0, OSR);
    drive(1'b1, OSR);
    drive(1'b0, 8);
    rstn = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    rx = 1'b1;
    e_valid = 0; e_data = '0; e_fe = 0; e_pe = 0; e_ovr = 0;
    n_cmp++;
    if ({busy, obs()} !== 13'h0) begin n_bad++; $display("FAIL reset_midframe: got %h want 0000", {busy, obs()}); end
    drive(1'b1, 40);
    n_cmp++;
    if ({busy, obs()} !== {1'b0, mdl()}) begin n_bad++; $display("FAIL reset_no_output: got %h want %h", {busy, obs()}, {1'b0, mdl()}); end
  endtask

  task automatic test_random();
    int lens[6] = '{3, 5, 6, 7, 8, 12};
    tk(1);
    for (int it = 0; it < 8; it++) begin
      send_frame(8'($urandom), lens[$urandom_range(5)], 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom), -1, 24);
      n_cmp++;
      if (obs() !== mdl()) begin n_bad++; $display("FAIL random_frame_%0d: got %h want %h", it, obs(), mdl()); end
      consume();
      n_cmp++;
      if (obs() !== mdl()) begin n_bad++; $display("FAIL random_consume_%0d: got %h want %h", it, obs(), mdl()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity_7e2();
    test_overrun();
    test_glitch();
    test_rx_en_drop();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
